// File: rtl/lrf_pkg.sv
// Shared types and size helpers for the frame-buffer LSU scheduler.
package lrf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam int MAX_PIPE_LAT = 8;

    function automatic int calc_mem_depth(input int dim, input int ppb);
        return (dim * dim) / ppb;
    endfunction

    // A one-beat frame would still need a 1-bit address.
    function automatic int calc_addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/lsu_wb_delay.sv
// Valid+address delay line: a token entering here emerges DEPTH cycles later
// as the write-back strobe and address.
module lsu_wb_delay #(
    parameter int DEPTH = 2,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic          early_pending
);

    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] valid_next;
    logic [AW-1:0]    addr_reg  [DEPTH];
    logic [AW-1:0]    addr_next [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign valid_next[gi] = in_valid;
                assign addr_next[gi]  = in_addr;
            end else begin : g_tail
                assign valid_next[gi] = valid_reg[gi-1];
                assign addr_next[gi]  = addr_reg[gi-1];
            end
        end

        // Tokens still upstream of the output stage; empty means the pipe drains this cycle.
        if (DEPTH > 1) begin : g_pending
            assign early_pending = |valid_reg[DEPTH-2:0];
        end else begin : g_no_pending
            assign early_pending = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            valid_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_reg[i] <= '0;
            end
        end else begin
            valid_reg <= valid_next;
            for (int i = 0; i < DEPTH; i++) begin
                addr_reg[i] <= addr_next[i];
            end
        end
    end

    assign out_valid = valid_reg[DEPTH-1];
    assign out_addr  = addr_reg[DEPTH-1];

endmodule

// File: rtl/lsu_frame_sched.sv
// Per-frame read-modify-write sequencer: reads word k on each accepted beat and
// writes word k back a fixed PIPE_LAT cycles later.
module lsu_frame_sched
    import lrf_pkg::*;
#(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int BIT_WIDTH       = 8,
    parameter int PIPE_LAT        = 2,
    parameter int MEM_DEPTH       = calc_mem_depth(IMAGE_DIM, PIXELS_PER_BEAT),
    parameter int ADDR_WIDTH      = calc_addr_width(MEM_DEPTH),
    parameter int FCNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  start,
    input  logic                  clear_history,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_last,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic                  first_frame,
    output logic                  busy,
    output logic                  done,
    output logic                  last_err,
    output logic [FCNT_WIDTH-1:0] frame_cnt
);

    generate
        if (PIPE_LAT < 1 || PIPE_LAT > MAX_PIPE_LAT || MEM_DEPTH <= PIPE_LAT || BIT_WIDTH < 1) begin : g_bad_params
            $error("lsu_frame_sched: illegal parameterisation");
        end
    endgenerate

    localparam logic [ADDR_WIDTH-1:0] LAST_BEAT = ADDR_WIDTH'(MEM_DEPTH - 1);

    state_e                  state_reg;
    state_e                  state_next;
    logic [ADDR_WIDTH-1:0]   beat_cnt_reg;
    logic [FCNT_WIDTH-1:0]   frame_cnt_reg;
    logic                    first_frame_reg;
    logic                    last_err_reg;

    logic accept;
    logic last_beat;
    logic early_pending;
    logic frame_done;

    assign accept     = s_valid && (state_reg == RUN);
    assign last_beat  = (beat_cnt_reg == LAST_BEAT);
    assign frame_done = (state_reg == FLUSH) && !early_pending;

    lsu_wb_delay #(
        .DEPTH (PIPE_LAT),
        .AW    (ADDR_WIDTH)
    ) u_wb_delay (
        .clk           (clk),
        .areset        (areset),
        .in_valid      (accept),
        .in_addr       (beat_cnt_reg),
        .out_valid     (mem_we),
        .out_addr      (mem_waddr),
        .early_pending (early_pending)
    );

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (accept && last_beat) state_next = FLUSH;
            FLUSH:   if (!early_pending) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state_reg == RUN);
        busy    = (state_reg != IDLE);
        mem_re  = accept;
        // Only the final token can be at the output once nothing is queued behind it.
        done    = (state_reg == FLUSH) && mem_we && !early_pending;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            beat_cnt_reg    <= '0;
            frame_cnt_reg   <= '0;
            first_frame_reg <= 1'b1;
            last_err_reg    <= 1'b0;
        end else begin
            if (accept) begin
                beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + 1'b1;
            end

            if (frame_done) begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end

            // A history clear alongside start wins, so the new frame bypasses history.
            if (state_reg == IDLE && clear_history) begin
                first_frame_reg <= 1'b1;
            end else if (frame_done) begin
                first_frame_reg <= 1'b0;
            end

            if (state_reg == IDLE && start) begin
                last_err_reg <= 1'b0;
            end else if (accept && (s_last != last_beat)) begin
                last_err_reg <= 1'b1;
            end
        end
    end

    assign mem_raddr   = beat_cnt_reg;
    assign frame_cnt   = frame_cnt_reg;
    assign first_frame = first_frame_reg;
    assign last_err    = last_err_reg;

endmodule
